// File: rtl/idex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX stage: control-word bit positions and state encoding.
package idex_pkg;

  localparam int CTRL_W_DEF   = 9;

  localparam int ALUOP_LSB    = 7;
  localparam int ALUOP_MSB    = 8;
  localparam int REGWRITE_BIT = 6;
  localparam int MEMTOREG_BIT = 5;
  localparam int BRANCH_BIT   = 4;
  localparam int MEMWRITE_BIT = 3;
  localparam int MEMREAD_BIT  = 2;
  localparam int ALUSRC_BIT   = 1;
  localparam int REGDST_BIT   = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } idex_state_e;

endpackage

// File: rtl/idex_pipe_reg_if.sv
// Decode-to-execute bundle: input handshake, output handshake, payload, flush and stall count.
interface idex_pipe_reg_if
  import idex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int STAT_W  = 16
);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_pc;
  logic [DATA_W-1:0]  in_rs_data;
  logic [DATA_W-1:0]  in_rt_data;
  logic [DATA_W-1:0]  in_imm;
  logic [RADDR_W-1:0] in_rt;
  logic [RADDR_W-1:0] in_rd;
  logic [FUNCT_W-1:0] in_funct;
  logic [CTRL_W-1:0]  in_ctrl;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_pc;
  logic [DATA_W-1:0]  out_rs_data;
  logic [DATA_W-1:0]  out_rt_data;
  logic [DATA_W-1:0]  out_imm;
  logic [RADDR_W-1:0] out_rt;
  logic [RADDR_W-1:0] out_rd;
  logic [FUNCT_W-1:0] out_funct;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [STAT_W-1:0]  stall_cnt;

  // The master drives decode-side payload and the execute-side ready.
  modport master (
    output flush, in_valid, in_pc, in_rs_data, in_rt_data, in_imm,
           in_rt, in_rd, in_funct, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_rs_data, out_rt_data, out_imm,
           out_rt, out_rd, out_funct, out_ctrl, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs_data, in_rt_data, in_imm,
           in_rt, in_rd, in_funct, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_rs_data, out_rt_data, out_imm,
           out_rt, out_rd, out_funct, out_ctrl, stall_cnt
  );

endinterface

// File: rtl/idex_pipe_reg_payload.sv
// One payload entry: data with load enable, control word with a clear that wins over load.
module idex_payload_reg
  import idex_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int CTRL_BITS = CTRL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_clrCtrl,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic [CTRL_BITS-1:0] i_ctrl,
  output logic [DATA_BITS-1:0] o_data,
  output logic [CTRL_BITS-1:0] o_ctrl
);

  logic [DATA_BITS-1:0] r_data;
  logic [CTRL_BITS-1:0] r_ctrl;

  // Clearing the control word whenever the entry goes invalid keeps bubbles harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else begin
      if (i_load) r_data <= i_data;
      if (i_clrCtrl)   r_ctrl <= '0;
      else if (i_load) r_ctrl <= i_ctrl;
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid/ready, flush and saturating stall count.
// Define IDEX_SKID_EN to add a skid entry and register in_ready.
module idex_pipe_reg
  import idex_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int STAT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  idex_pipe_reg_if.slave bus
);

  localparam int PAY_W = 4*DATA_W + 2*RADDR_W + FUNCT_W;
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  idex_state_e       r_state;
  idex_state_e       w_nextState;
  logic              r_outValid;
  logic              w_inReady;
  logic              w_inXfer;
  logic              w_outXfer;
  logic              w_mainLoad;
  logic              w_mainClr;
  logic [PAY_W-1:0]  w_inPay;
  logic [PAY_W-1:0]  w_mainD;
  logic [PAY_W-1:0]  w_mainQ;
  logic [CTRL_W-1:0] w_mainCtrlD;
  logic [CTRL_W-1:0] w_mainCtrlQ;
  logic [STAT_W-1:0] r_stallCnt;

  assign w_inPay   = {bus.in_pc, bus.in_rs_data, bus.in_rt_data, bus.in_imm,
                      bus.in_rt, bus.in_rd, bus.in_funct};
  assign w_inXfer  = bus.in_valid && w_inReady;
  assign w_outXfer = r_outValid && bus.out_ready;

`ifdef IDEX_SKID_EN
  logic              r_inReady;
  logic              w_skidLoad;
  logic              w_fromSkid;
  logic [PAY_W-1:0]  w_skidQ;
  logic [CTRL_W-1:0] w_skidCtrlQ;

  assign w_inReady   = r_inReady;
  assign w_mainD     = w_fromSkid ? w_skidQ : w_inPay;
  assign w_mainCtrlD = w_fromSkid ? w_skidCtrlQ : bus.in_ctrl;

  idex_payload_reg #(.DATA_BITS(PAY_W), .CTRL_BITS(CTRL_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skidLoad),
    .i_clrCtrl(w_nextState != ST_SKID),
    .i_data   (w_inPay),
    .i_ctrl   (bus.in_ctrl),
    .o_data   (w_skidQ),
    .o_ctrl   (w_skidCtrlQ)
  );

  // Registered ready: decode only sees whether a slot will be free next cycle.
  always_ff @(posedge clk) begin
    if (rst) r_inReady <= 1'b1;
    else     r_inReady <= (w_nextState != ST_SKID);
  end
`else
  assign w_inReady   = !r_outValid || bus.out_ready;
  assign w_mainD     = w_inPay;
  assign w_mainCtrlD = bus.in_ctrl;
`endif

  always_comb begin
    w_nextState = r_state;
    w_mainLoad  = 1'b0;
`ifdef IDEX_SKID_EN
    w_skidLoad  = 1'b0;
    w_fromSkid  = 1'b0;
`endif
    case (r_state)
      ST_EMPTY: begin
        if (w_inXfer) begin
          w_nextState = ST_FULL;
          w_mainLoad  = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_inXfer) begin
`ifdef IDEX_SKID_EN
          if (w_outXfer) begin
            w_mainLoad = 1'b1;
          end else begin
            w_nextState = ST_SKID;
            w_skidLoad  = 1'b1;
          end
`else
          w_mainLoad = 1'b1;
`endif
        end else if (w_outXfer) begin
          w_nextState = ST_EMPTY;
        end
      end
`ifdef IDEX_SKID_EN
      ST_SKID: begin
        if (w_outXfer) begin
          w_nextState = ST_FULL;
          w_mainLoad  = 1'b1;
          w_fromSkid  = 1'b1;
        end
      end
`endif
      default: w_nextState = ST_EMPTY;
    endcase
    // Flush drops both held entries and anything arriving this cycle.
    if (bus.flush) begin
      w_nextState = ST_EMPTY;
      w_mainLoad  = 1'b0;
`ifdef IDEX_SKID_EN
      w_skidLoad  = 1'b0;
`endif
    end
  end

  assign w_mainClr = (w_nextState == ST_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_outValid <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_outValid <= (w_nextState != ST_EMPTY);
    end
  end

  idex_payload_reg #(.DATA_BITS(PAY_W), .CTRL_BITS(CTRL_W)) u_main (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_mainLoad),
    .i_clrCtrl(w_mainClr),
    .i_data   (w_mainD),
    .i_ctrl   (w_mainCtrlD),
    .o_data   (w_mainQ),
    .o_ctrl   (w_mainCtrlQ)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_stallCnt <= '0;
    else if (r_outValid && !bus.out_ready && !bus.flush && (r_stallCnt != '1))
      r_stallCnt <= r_stallCnt + STAT_ONE;
  end

  assign {bus.out_pc, bus.out_rs_data, bus.out_rt_data, bus.out_imm,
          bus.out_rt, bus.out_rd, bus.out_funct} = w_mainQ;
  assign bus.out_ctrl  = w_mainCtrlQ;
  assign bus.out_valid = r_outValid;
  assign bus.in_ready  = w_inReady;
  assign bus.stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Directed bench for idex_pipe_reg: streaming table, stall, flush, reset and saturation sequences.
module tb_idex_pipe_reg;
  import idex_pkg::*;

`ifdef IDEX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [8:0] CTRL_RTYPE = (9'd2 << ALUOP_LSB) | (9'd1 << REGWRITE_BIT) | (9'd1 << REGDST_BIT);
  localparam logic [8:0] CTRL_LOAD  = (9'd1 << REGWRITE_BIT) | (9'd1 << MEMTOREG_BIT) |
                                      (9'd1 << MEMREAD_BIT) | (9'd1 << ALUSRC_BIT);

  logic clk = 1'b0;
  logic rst;
  int   passCount = 0;
  int   totalCount = 0;

  idex_pipe_reg_if bus1 ();
  idex_pipe_reg_if #(.STAT_W(4)) bus2 ();

  idex_pipe_reg dut (.clk(clk), .rst(rst), .bus(bus1));
  idex_pipe_reg #(.STAT_W(4)) dutSat (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        r;
    logic [31:0] pc;
    logic [8:0]  ctrl;
    logic        expValid;
    logic        expReady;
    logic [31:0] expPc;
    logic [8:0]  expCtrl;
    logic [15:0] expStall;
    logic        chkPay;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] rsOf(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic applyStimulus(input logic v, input logic r, input logic f, input logic rs,
                               input logic [31:0] pc, input logic [8:0] ctrl);
    rst             = rs;
    bus1.flush      = f;
    bus1.in_valid   = v;
    bus1.out_ready  = r;
    bus1.in_pc      = pc;
    bus1.in_rs_data = rsOf(pc);
    bus1.in_rt_data = pc + 32'd1;
    bus1.in_imm     = ~pc;
    bus1.in_rt      = pc[4:0];
    bus1.in_rd      = pc[6:2];
    bus1.in_funct   = pc[7:2];
    bus1.in_ctrl    = ctrl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkState(input string tag, input logic ov, input logic ir,
                            input logic [31:0] pc, input logic chkPc, input logic [15:0] st);
    checkOutput({tag, " out_valid"}, 32'(bus1.out_valid), 32'(ov));
    checkOutput({tag, " in_ready"}, 32'(bus1.in_ready), 32'(ir));
    checkOutput({tag, " stall_cnt"}, 32'(bus1.stall_cnt), 32'(st));
    if (!ov) checkOutput({tag, " out_ctrl bubble"}, 32'(bus1.out_ctrl), 32'd0);
    if (chkPc) checkOutput({tag, " out_pc"}, bus1.out_pc, pc);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{v: 1'b1, r: 1'b1, pc: 32'h100 + 32'(4*i), ctrl: CTRL_RTYPE ^ 9'(i << 1),
                  expValid: 1'b1, expReady: 1'b1, expPc: 32'h100 + 32'(4*i),
                  expCtrl: CTRL_RTYPE ^ 9'(i << 1), expStall: 16'd0, chkPay: 1'b1};
    end
    vecs[8] = '{v: 1'b0, r: 1'b1, pc: 32'h0, ctrl: 9'h0, expValid: 1'b0, expReady: 1'b1,
                expPc: 32'h0, expCtrl: 9'h0, expStall: 16'd0, chkPay: 1'b0};
    vecs[9] = '{v: 1'b0, r: 1'b0, pc: 32'h0, ctrl: 9'h0, expValid: 1'b0, expReady: 1'b1,
                expPc: 32'h0, expCtrl: 9'h0, expStall: 16'd0, chkPay: 1'b0};

    bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
    bus2.in_pc = '0; bus2.in_rs_data = '0; bus2.in_rt_data = '0; bus2.in_imm = '0;
    bus2.in_rt = '0; bus2.in_rd = '0; bus2.in_funct = '0; bus2.in_ctrl = '0;

    // Reset state: in_valid high during reset must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_0000, CTRL_LOAD);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_0004, CTRL_LOAD);
    checkState("reset", 1'b0, 1'b1, 32'h0, 1'b1, 16'd0);

    // Streaming table: each entry shows up one edge after it is presented.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].v, vecs[i].r, 1'b0, 1'b0, vecs[i].pc, vecs[i].ctrl);
      checkOutput($sformatf("stream%0d out_valid", i), 32'(bus1.out_valid), 32'(vecs[i].expValid));
      checkOutput($sformatf("stream%0d in_ready", i), 32'(bus1.in_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("stream%0d out_ctrl", i), 32'(bus1.out_ctrl), 32'(vecs[i].expCtrl));
      checkOutput($sformatf("stream%0d stall_cnt", i), 32'(bus1.stall_cnt), 32'(vecs[i].expStall));
      if (vecs[i].chkPay) begin
        checkOutput($sformatf("stream%0d out_pc", i), bus1.out_pc, vecs[i].expPc);
        checkOutput($sformatf("stream%0d out_rs_data", i), bus1.out_rs_data, rsOf(vecs[i].expPc));
        checkOutput($sformatf("stream%0d out_imm", i), bus1.out_imm, ~vecs[i].expPc);
        checkOutput($sformatf("stream%0d out_rd", i), 32'(bus1.out_rd), 32'(vecs[i].expPc[6:2]));
        checkOutput($sformatf("stream%0d out_funct", i), 32'(bus1.out_funct), 32'(vecs[i].expPc[7:2]));
      end
    end

    // Downstream stall for three counted cycles, then drain in order.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, CTRL_RTYPE);
    checkState("stall e1", 1'b1, SKID, 32'h200, 1'b1, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h204, CTRL_LOAD);
    checkState("stall e2", 1'b1, 1'b0, 32'h200, 1'b1, 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h204, CTRL_LOAD);
    checkState("stall e3", 1'b1, 1'b0, 32'h200, 1'b1, 16'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h204, CTRL_LOAD);
    checkState("stall e4", 1'b1, 1'b0, 32'h200, 1'b1, 16'd3);
    checkOutput("stall e4 out_ctrl held", 32'(bus1.out_ctrl), 32'(CTRL_RTYPE));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h204, CTRL_LOAD);
    checkState("stall e5", 1'b1, 1'b1, 32'h204, 1'b1, 16'd3);
    checkOutput("stall e5 out_ctrl", 32'(bus1.out_ctrl), 32'(CTRL_LOAD));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 9'h0);
    checkState("stall e6", 1'b0, 1'b1, 32'h0, 1'b0, 16'd3);

    // Flush with both slots occupied (or held, without skid) and an entry arriving.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, CTRL_RTYPE);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h304, CTRL_RTYPE);
    checkState("flush pre", 1'b1, 1'b0, 32'h300, 1'b1, 16'd4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h308, CTRL_LOAD);
    checkState("flush e1", 1'b0, 1'b1, 32'h0, 1'b0, 16'd4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 9'h0);
      checkState($sformatf("flush drain%0d", i), 1'b0, 1'b1, 32'h0, 1'b0, 16'd4);
    end

    // Flush while FULL with in_ready high: the incoming entry must also vanish.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, CTRL_RTYPE);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h404, CTRL_LOAD);
    checkState("flush full", 1'b0, 1'b1, 32'h0, 1'b0, 16'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 9'h0);
    checkState("flush full after", 1'b0, 1'b1, 32'h0, 1'b0, 16'd4);

    // Reset mid-stream while FULL, then a normal accept.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, CTRL_RTYPE);
    checkState("rst pre", 1'b1, SKID, 32'h500, 1'b1, 16'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h504, CTRL_LOAD);
    checkState("rst mid", 1'b0, 1'b1, 32'h0, 1'b1, 16'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h508, CTRL_LOAD);
    checkState("rst after", 1'b1, 1'b1, 32'h508, 1'b1, 16'd0);
    checkOutput("rst after out_ctrl", 32'(bus1.out_ctrl), 32'(CTRL_LOAD));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 9'h0);
    checkState("rst drain", 1'b0, 1'b1, 32'h0, 1'b0, 16'd0);

    // Saturation on the 4-bit counter instance: 20 stall cycles pin it at 15.
    bus2.in_valid  = 1'b1;
    bus2.in_ctrl   = CTRL_RTYPE;
    bus2.out_ready = 1'b0;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    checkOutput("sat start", 32'(bus2.stall_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 4)  checkOutput("sat count5", 32'(bus2.stall_cnt), 32'd5);
      if (i == 14) checkOutput("sat reach15", 32'(bus2.stall_cnt), 32'd15);
    end
    checkOutput("sat hold15", 32'(bus2.stall_cnt), 32'd15);
    checkOutput("sat out_valid", 32'(bus2.out_valid), 32'd1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/idex_pipe_reg.md
# idex_pipe_reg

Parametrised ID/EX pipeline stage register with valid/ready flow control, synchronous flush and stall accounting. It sits between the decode stage and the execute stage and carries operands, immediate, register addresses, funct and a packed control word. Unlike a free-running latch, it supports several behaviours:
- it holds on downstream stall;
- it inserts bubbles on flush;
- it optionally decouples `in_ready` from `out_ready` through a skid entry.

## Interface
Parameters:
- `DATA_W`, 32: operand, PC and immediate width.
- `RADDR_W`, 5: register-address width (rt, rd).
- `FUNCT_W`, 6: funct field width.
- `CTRL_W`, 9: packed control width (ALUOp[1:0], regWrite, memToReg, branch, memWrite, memRead, ALUSrc, RegDst).
- `STAT_W`, 16: stall counter width.

Ports (name, direction, width, meaning):
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all held and incoming entries.
- `in_valid` in 1: decode presents an entry.
- `in_ready` out 1: stage accepts an entry this cycle.
- `in_pc`, `in_rs_data`, `in_rt_data`, `in_imm` in DATA_W each: payload.
- `in_rt`, `in_rd` in RADDR_W each: payload.
- `in_funct` in FUNCT_W: payload.
- `in_ctrl` in CTRL_W: payload.
- `out_valid` out 1: entry presented to execute.
- `out_ready` in 1: execute consumes the entry this cycle.
- `out_pc`, `out_rs_data`, `out_rt_data`, `out_imm`, `out_rt`, `out_rd`, `out_funct`, `out_ctrl` out: payload, same widths as inputs.
- `stall_cnt` out STAT_W: saturating count of stall cycles.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
  - The payload is captured unmodified; the block performs no arithmetic on it.
- Reset state:
  - `out_valid`=0, `out_ctrl`=0, `stall_cnt`=0, skid entry empty, `in_ready`=1.
  - Other payload outputs reset to 0.
- Output payload:
  - Held stable while `out_valid && !out_ready`.
  - `out_ctrl` is forced to 0 whenever `out_valid`=0, so a bubble never writes registers or memory.
  - Non-control payload is don't-care when invalid.
- States: EMPTY, FULL (main register valid), and SKID (main and skid valid; exists only with the macro).
  - EMPTY → FULL on input transfer.
  - FULL → EMPTY on output transfer with no input transfer.
  - FULL → FULL on simultaneous input and output transfer; the new entry replaces the old one.
  - FULL → SKID on input transfer without output transfer.
  - SKID → FULL on output transfer; the skid entry moves to main and no input is accepted.
- Flush:
  - Next state is EMPTY; both entries are dropped.
  - An input transfer in the same cycle is also dropped.
  - `flush` overrides every other event; `rst` overrides `flush`.
- `stall_cnt`:
  - Increments each cycle `out_valid && !out_ready && !flush`.
  - Saturates at 2^STAT_W−1, with no wrap.
  - Cleared only by `rst`.

## Timing
- Latency: an entry accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput: one entry per cycle when `out_ready` is continuously high.
- `out_valid` and all out payload are driven directly from flops.
- `in_ready` is combinational or registered depending on configuration (see Configuration).
- A single-cycle `flush` gives `out_valid`=0 the following cycle and `in_ready`=1 the following cycle.
- `in_valid` is ignored while `rst`=1.

## Configuration
- `IDEX_SKID_EN` defined:
  - Second (skid) entry is instantiated.
  - `in_ready` is a flop equal to !(state==SKID), with no combinational path from `out_ready`.
  - Up to two entries are buffered.
- `IDEX_SKID_EN` undefined:
  - No skid entry; SKID state is absent.
  - `in_ready` = `!out_valid || out_ready` (combinational).
  - At most one entry is buffered.

## Structure
- Shared package `idex_pkg`:
  - Control-field bit positions (ALUOP_LSB, REGWRITE_BIT, …, REGDST_BIT).
  - CTRL_W default.
  - State-encoding typedef (EMPTY/FULL/SKID).
- One natural sub-module, `idex_payload_reg`: a payload register with load enable and control-word clear, instantiated for main and skid.
- Top level holds the state machine, the `in_ready` logic and `stall_cnt`.

## Test plan
- Streaming: 8 back-to-back entries with `out_ready`=1 (in_pc=0x100,0x104,…) → each appears exactly 1 cycle later, in order, with no gaps.
- Stall, with skid: `out_ready`=0 for 3 cycles while `in_valid`=1 → `in_ready` drops after the 2nd accept, `stall_cnt`=3, and both entries drain in order once `out_ready`=1. Without skid: `in_ready` drops after the 1st accept.
- Flush in SKID with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1, and no held or incoming entry ever appears at the output.
- Reset mid-stream with `rst`=1 for 1 cycle while FULL → `out_valid`=0, `stall_cnt`=0, `out_ctrl`=0; the next entry is accepted normally.
- Saturation with STAT_W=4: 20 stall cycles → `stall_cnt` holds 15.
